dbg_trace_buffer: RTL and testbench
===================================

# dbg_trace_buffer

Parametrised on-chip execution trace recorder for the single-cycle RISC-V core. It samples the core's debug bus (`dbg_pc`, `dbg_instr`, `dbg_ALU_result`, `dbg_ALU_ctrl`, `dbg_wr_en`) into a circular buffer. It supports three capture modes, including a PC-match trigger with pre- and post-trigger history, which replaces ad-hoc simulation printing with a synthesizable trace that can be read out. It sits beside `risc_v`, connected to its `dbg_*` outputs, and is drained through a one-entry-per-request read handshake.

## Interface
- `XLEN`, 32: width of PC, instruction and ALU result fields.
- `DEPTH`, 16: number of trace entries; must be a power of two, ≥ 4.
- `POST_TRIG`, 8: samples recorded after the trigger sample in mode 2; must satisfy 1 ≤ `POST_TRIG` < `DEPTH`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `arm`  in  1  one-cycle pulse; starts a new capture.
- `mode`  in  2  latched at `arm`: 0 = all cycles, 1 = write-back cycles only, 2 = PC trigger, 3 = treated as 0.
- `trig_pc`  in  XLEN  trigger address; latched at `arm`.
- `dbg_pc`, `dbg_instr`, `dbg_ALU_result`  in  XLEN each  core debug bus.
- `dbg_ALU_ctrl`  in  4  core debug bus.
- `dbg_wr_en`  in  1  core debug bus.
- `rd_req`  in  1  request the oldest entry.
- `rd_valid`  out  1  read data valid, one cycle.
- `rd_pc`, `rd_instr`, `rd_result`  out  XLEN each  read data.
- `rd_ctrl`  out  4  read data.
- `rd_wr_en`  out  1  read data.
- `count`  out  $clog2(DEPTH)+1  number of entries held.
- `state`  out  2  FSM state.
- `done`  out  1  high while in DONE.
- `overflow`  out  1  set when any entry was overwritten.

## Operation
- **States** (encoding in parentheses):
  - IDLE (0): no sampling.
  - ARMED (1): mode 2 pre-trigger.
  - CAPTURE (2): recording.
  - DONE (3): readout.
- **`arm`**, accepted in any state:
  - clears write/read pointers, `count`, `overflow` and the post-trigger counter;
  - latches `mode` and `trig_pc`;
  - next state is ARMED for mode 2, CAPTURE otherwise.
- **ARMED:**
  - Writes a sample every cycle.
  - When full, it overwrites the oldest entry: the read pointer advances with the write pointer, `count` saturates at `DEPTH`, and `overflow` is set.
  - When `dbg_pc == trig_pc`, it records that sample and moves to CAPTURE with the post-trigger counter = `POST_TRIG`.
- **CAPTURE, mode 0:** writes every cycle.
- **CAPTURE, mode 1:** writes only when `dbg_wr_en` = 1.
  - Modes 0/1 go to DONE on the write that makes `count` = `DEPTH`; no overwrite occurs.
- **CAPTURE, mode 2:**
  - Writes every cycle with the same overwrite rule as ARMED, and decrements the post-trigger counter.
  - The write at counter = 1 is the last; the FSM then goes to DONE.
- **DONE:**
  - No sampling.
  - `rd_req` with `count` > 0 returns the oldest entry, advances the read pointer and decrements `count`.
  - `rd_req` with `count` = 0 is ignored (`rd_valid` stays 0).
  - The FSM stays in DONE until `arm`.
- `rd_req` outside DONE is ignored.
- `arm` and `rd_req` in the same cycle: `arm` wins and no read is issued.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
- **Reset:**
  - `state` = IDLE.
  - `count`, pointers, `done`, `overflow`, `rd_valid` and all `rd_*` data = 0.
  - Reset mid-capture or mid-readout discards all entries.

## Timing
- Samples are taken on the rising edge of the qualifying cycle; `count` reflects the write in the following cycle.
- Trigger compare uses the current-cycle `dbg_pc`; the trigger instruction is always entry index `count-1-POST_TRIG` of the final trace.
- Read latency is 1: `rd_req` in cycle N gives `rd_valid` and data in cycle N+1.
- Back-to-back `rd_req` gives one entry per cycle.
- `rd_*` data holds its last value when `rd_valid` = 0.
- `done` rises the cycle after the final write.
- A write followed by a read of the same entry is impossible, because reads occur only in DONE.

## Structure
- Package `dbg_trace_pkg` holds:
  - the FSM state enum;
  - mode encodings `MODE_ALL`, `MODE_WB`, `MODE_TRIG`;
  - the entry struct `{pc, instr, result, ctrl, wr_en}`, width 3·XLEN+5.
- Sub-module `trace_ram`: `DEPTH` × entry width, one write port and one synchronous read port; this provides the 1-cycle read latency.
- The FSM, pointers and counters live in `dbg_trace_buffer`.

## Test plan
- **Mode 0, `DEPTH`=16:** arm while the core runs from `PC` 0x0 →
  - DONE after 16 cycles, `count`=16;
  - 16 reads return `PC` 0x0, 0x4, …, 0x3C in order;
  - `overflow`=0.
- **Mode 1:** program with alternating write/no-write instructions → only entries with `rd_wr_en`=1 are stored, and their `rd_pc` values match the write-back instructions.
- **Mode 2, `trig_pc`=0x40, `POST_TRIG`=8, straight-line code:**
  - DONE after the 0x60 sample;
  - `count`=16, `overflow`=1;
  - first entry 0x24, last entry 0x60;
  - entry 7 = 0x40.
- **Mode 2 with the trigger at the first armed cycle** → `count`=9, `overflow`=0.
- **`rd_req` held for 20 cycles in DONE with `count`=16** → exactly 16 `rd_valid` pulses, then `count`=0; later requests are ignored.
- **Reset and arm mid-operation:**
  - `rst` asserted mid-CAPTURE → immediate IDLE with `count`=0 and all outputs 0;
  - `arm` during DONE readout → restart in which the read in the same cycle is suppressed.

Source files
------------

// File: rtl/dbg_trace_pkg.sv
// Shared types for the execution trace recorder: FSM states, capture
// modes and the layout of one recorded trace entry.
package dbg_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_e;

  localparam logic [1:0] MODE_ALL  = 2'd0;
  localparam logic [1:0] MODE_WB   = 2'd1;
  localparam logic [1:0] MODE_TRIG = 2'd2;

  // Canonical entry layout for the 32-bit core; modules with another XLEN
  // keep the same field order so entries stay interchangeable.
  localparam int TRACE_XLEN = 32;

  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic [TRACE_XLEN-1:0] instr;
    logic [TRACE_XLEN-1:0] result;
    logic [3:0]            ctrl;
    logic                  wr_en;
  } trace_entry_t;

  // Storage width of one entry: pc, instr, result, 4-bit ctrl and wr_en.
  function automatic int entry_width(input int xlen);
    return 3 * xlen + 5;
  endfunction

endpackage

// File: rtl/dbg_trace_buffer_if.sv
// Bundle of the trace recorder's control, core debug bus and readout
// signals. The recorder uses the slave view, the core/debugger the master.
interface dbg_trace_buffer_if
  import dbg_trace_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
) ();

  logic                       arm;
  logic [1:0]                 mode;
  logic [XLEN-1:0]            trig_pc;

  logic [XLEN-1:0]            dbg_pc;
  logic [XLEN-1:0]            dbg_instr;
  logic [XLEN-1:0]            dbg_ALU_result;
  logic [3:0]                 dbg_ALU_ctrl;
  logic                       dbg_wr_en;

  logic                       rd_req;
  logic                       rd_valid;
  logic [XLEN-1:0]            rd_pc;
  logic [XLEN-1:0]            rd_instr;
  logic [XLEN-1:0]            rd_result;
  logic [3:0]                 rd_ctrl;
  logic                       rd_wr_en;

  logic [$clog2(DEPTH):0]     count;
  trace_state_e               state;
  logic                       done;
  logic                       overflow;

  modport master (
    output arm, mode, trig_pc,
    output dbg_pc, dbg_instr, dbg_ALU_result, dbg_ALU_ctrl, dbg_wr_en,
    output rd_req,
    input  rd_valid, rd_pc, rd_instr, rd_result, rd_ctrl, rd_wr_en,
    input  count, state, done, overflow
  );

  modport slave (
    input  arm, mode, trig_pc,
    input  dbg_pc, dbg_instr, dbg_ALU_result, dbg_ALU_ctrl, dbg_wr_en,
    input  rd_req,
    output rd_valid, rd_pc, rd_instr, rd_result, rd_ctrl, rd_wr_en,
    output count, state, done, overflow
  );

endinterface

// File: rtl/dbg_trace_buffer_trace_ram.sv
// Trace storage: DEPTH x WIDTH array with one write port and one registered
// read port. The read register gives the one-cycle readout latency and
// holds its value between reads.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 101
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  // Array contents are not reset; a cleared count makes them unreachable.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Load the read register only on a read so data holds otherwise.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  // Read register returns to zero on reset so readout outputs start clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dbg_trace_buffer.sv
// Execution trace recorder for the single-cycle RISC-V core. Samples the
// core debug bus into a circular buffer in one of three capture modes and
// drains it one entry per read request once capture is complete.
module dbg_trace_buffer
  import dbg_trace_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic             clk,
  input  logic             rst,
  dbg_trace_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = entry_width(XLEN);

  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [PW-1:0] POST_INIT = PW'(POST_TRIG);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] result;
    logic [3:0]      ctrl;
    logic            wr_en;
  } entry_t;

  trace_state_e    state_q,    state_d;
  logic [PW-1:0]   wptr_q,     wptr_d;
  logic [PW-1:0]   rptr_q,     rptr_d;
  logic [PW-1:0]   post_q,     post_d;
  logic [CW-1:0]   count_q,    count_d;
  logic            overflow_q, overflow_d;
  logic [1:0]      mode_q,     mode_d;
  logic [XLEN-1:0] trig_pc_q,  trig_pc_d;
  logic            rd_valid_q, rd_valid_d;

  logic            ring_wr;
  logic            lin_wr;
  logic            ram_we;
  logic            ram_re;
  entry_t          wr_entry;
  entry_t          rd_entry;
  logic [EW-1:0]   ram_rdata;

  assign wr_entry = '{pc:     bus.dbg_pc,
                      instr:  bus.dbg_instr,
                      result: bus.dbg_ALU_result,
                      ctrl:   bus.dbg_ALU_ctrl,
                      wr_en:  bus.dbg_wr_en};

  // Next-state logic: arm restarts from any state; ring writes (trigger
  // mode) overwrite the oldest entry when full, linear writes (modes 0/1)
  // stop at full; reads only drain in DONE.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    post_d     = post_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    mode_d     = mode_q;
    trig_pc_d  = trig_pc_q;
    ring_wr    = 1'b0;
    lin_wr     = 1'b0;
    ram_re     = 1'b0;

    if (bus.arm) begin
      wptr_d     = '0;
      rptr_d     = '0;
      post_d     = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      trig_pc_d  = bus.trig_pc;
      mode_d     = (bus.mode == MODE_TRIG || bus.mode == MODE_WB) ? bus.mode : MODE_ALL;
      state_d    = (bus.mode == MODE_TRIG) ? ST_ARMED : ST_CAPTURE;
    end else begin
      case (state_q)
        ST_ARMED: begin
          ring_wr = 1'b1;
          if (bus.dbg_pc == trig_pc_q) begin
            state_d = ST_CAPTURE;
            post_d  = POST_INIT;
          end
        end
        ST_CAPTURE: begin
          if (mode_q == MODE_TRIG) begin
            ring_wr = 1'b1;
            post_d  = post_q - PW'(1);
            if (post_q == PW'(1)) state_d = ST_DONE;
          end else if (mode_q == MODE_ALL || bus.dbg_wr_en) begin
            lin_wr = 1'b1;
            if (count_q == FULL - CW'(1)) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.rd_req && count_q != '0) begin
            ram_re  = 1'b1;
            rptr_d  = rptr_q + PW'(1);
            count_d = count_q - CW'(1);
          end
        end
        default: ;
      endcase

      if (ring_wr) begin
        wptr_d = wptr_q + PW'(1);
        if (count_q == FULL) begin
          rptr_d     = rptr_q + PW'(1);
          overflow_d = 1'b1;
        end else begin
          count_d = count_q + CW'(1);
        end
      end

      if (lin_wr) begin
        wptr_d  = wptr_q + PW'(1);
        count_d = count_q + CW'(1);
      end
    end

    ram_we     = ring_wr | lin_wr;
    rd_valid_d = ram_re;
  end

  // Control registers; reset discards any capture in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      post_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      mode_q     <= MODE_ALL;
      trig_pc_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      post_q     <= post_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      mode_q     <= mode_d;
      trig_pc_q  <= trig_pc_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_trace_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (wptr_q),
    .wdata (wr_entry),
    .re    (ram_re),
    .raddr (rptr_q),
    .rdata (ram_rdata)
  );

  assign rd_entry     = ram_rdata;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_pc    = rd_entry.pc;
  assign bus.rd_instr = rd_entry.instr;
  assign bus.rd_result = rd_entry.result;
  assign bus.rd_ctrl  = rd_entry.ctrl;
  assign bus.rd_wr_en = rd_entry.wr_en;
  assign bus.count    = count_q;
  assign bus.state    = state_q;
  assign bus.done     = (state_q == ST_DONE);
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_dbg_trace_buffer.sv
// Testbench for dbg_trace_buffer: drives a synthetic core debug stream,
// predicts the stored trace from the capture-mode rules and checks the
// status outputs and every entry drained through the read port.
module tb_dbg_trace_buffer;

  localparam int XLEN      = 32;
  localparam int DEPTH     = 16;
  localparam int POST_TRIG = 8;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] result;
    logic [3:0]      ctrl;
    logic            wr_en;
  } smp_t;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  smp_t            stream[$];
  smp_t            exp_q[$];
  int              exp_last;
  logic            exp_ovf;
  logic [XLEN-1:0] last_pc;

  dbg_trace_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  dbg_trace_buffer #(
    .XLEN      (XLEN),
    .DEPTH     (DEPTH),
    .POST_TRIG (POST_TRIG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_sample(input smp_t s);
    bus.dbg_pc         = s.pc;
    bus.dbg_instr      = s.instr;
    bus.dbg_ALU_result = s.result;
    bus.dbg_ALU_ctrl   = s.ctrl;
    bus.dbg_wr_en      = s.wr_en;
  endtask

  task automatic make_sample(input logic [XLEN-1:0] pc, input logic wr, output smp_t s);
    s.pc     = pc;
    s.instr  = $urandom;
    s.result = $urandom;
    s.ctrl   = 4'($urandom_range(0, 15));
    s.wr_en  = wr;
  endtask

  // Reference model: which samples of the driven stream must end up in the
  // buffer, and at which stream index capture must stop.
  task automatic build_expected(input logic [1:0] m, input logic [XLEN-1:0] trig);
    int t;
    exp_q.delete();
    exp_last = -1;
    exp_ovf  = 1'b0;
    if (m == 2'd1) begin
      foreach (stream[i]) begin
        if (stream[i].wr_en) exp_q.push_back(stream[i]);
        if (exp_q.size() == DEPTH) begin
          exp_last = i;
          break;
        end
      end
    end else if (m == 2'd2) begin
      t = -1;
      foreach (stream[i]) if (t < 0 && stream[i].pc == trig) t = i;
      if (t >= 0) begin
        exp_last = t + POST_TRIG;
        exp_ovf  = (exp_last + 1 > DEPTH);
        for (int i = 0; i <= exp_last && i < stream.size(); i++) begin
          exp_q.push_back(stream[i]);
          if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
        end
      end
    end else begin
      for (int i = 0; i < DEPTH && i < stream.size(); i++) exp_q.push_back(stream[i]);
      exp_last = DEPTH - 1;
    end
  endtask

  task automatic arm_capture(input logic [1:0] m, input logic [XLEN-1:0] trig, input logic [XLEN-1:0] base);
    smp_t s;
    make_sample(base - 32'd4, 1'b0, s);
    drive_sample(s);
    bus.arm     = 1'b1;
    bus.mode    = m;
    bus.trig_pc = trig;
    tick();
    bus.arm = 1'b0;
    check("arm_state", bus.state, (m == 2'd2) ? 2'd1 : 2'd2);
    check("arm_count", bus.count, 0);
    check("arm_overflow", bus.overflow, 0);
  endtask

  // wr_style 1 alternates write-back / no-write cycles, 0 randomises them.
  task automatic feed(input logic [1:0] m, input logic [XLEN-1:0] trig,
                      input logic [XLEN-1:0] base, input int wr_style);
    smp_t s;
    stream.delete();
    for (int i = 0; i < 200; i++) begin
      make_sample(base + 32'(4 * i), (wr_style == 1) ? logic'(i % 2 == 0) : logic'($urandom_range(0, 1)), s);
      drive_sample(s);
      stream.push_back(s);
      tick();
      if (bus.done) break;
    end
    build_expected(m, trig);
    check("final_sample_index", stream.size() - 1, exp_last);
    check("done", bus.done, 1);
    check("done_state", bus.state, 2'd3);
    check("count", bus.count, exp_q.size());
    check("overflow", bus.overflow, exp_ovf);
  endtask

  task automatic capture(input logic [1:0] m, input logic [XLEN-1:0] trig,
                         input logic [XLEN-1:0] base, input int wr_style);
    arm_capture(m, trig, base);
    feed(m, trig, base, wr_style);
  endtask

  // Hold rd_req for ncyc cycles; each request yields the oldest expected
  // entry one cycle later until the model's queue is empty.
  task automatic readout(input int ncyc);
    smp_t got;
    smp_t exp;
    bus.rd_req = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      tick();
      if (exp_q.size() > 0) begin
        check("rd_valid", bus.rd_valid, 1);
        got = {bus.rd_pc, bus.rd_instr, bus.rd_result, bus.rd_ctrl, bus.rd_wr_en};
        exp = exp_q.pop_front();
        check("rd_entry", got, exp);
        last_pc = exp.pc;
      end else begin
        check("rd_valid_empty", bus.rd_valid, 0);
      end
    end
    bus.rd_req = 1'b0;
    tick();
    check("rd_valid_after", bus.rd_valid, 0);
    check("count_after_read", bus.count, exp_q.size());
    check("rd_pc_hold", bus.rd_pc, last_pc);
  endtask

  initial begin
    smp_t s;
    logic [XLEN-1:0] base;
    logic [1:0]      m;

    rst     = 1'b1;
    last_pc = '0;
    bus.arm = 1'b0;
    bus.mode = 2'd0;
    bus.trig_pc = '0;
    bus.rd_req = 1'b0;
    drive_sample('0);
    #3;
    check("reset_state", bus.state, 0);
    check("reset_count", bus.count, 0);
    check("reset_done", bus.done, 0);
    check("reset_overflow", bus.overflow, 0);
    check("reset_rd_valid", bus.rd_valid, 0);
    check("reset_rd_pc", bus.rd_pc, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("[TB] read request while idle");
    bus.rd_req = 1'b1;
    tick();
    tick();
    check("idle_rd_valid", bus.rd_valid, 0);
    check("idle_state", bus.state, 0);
    bus.rd_req = 1'b0;

    $display("[TB] mode 0 from PC 0x0");
    capture(2'd0, 32'h0, 32'h0, 0);
    readout(20);

    $display("[TB] mode 1 with alternating write-back");
    capture(2'd1, 32'h0, 32'h100, 1);
    readout(DEPTH + 2);

    $display("[TB] mode 2 trigger at 0x40");
    capture(2'd2, 32'h40, 32'h0, 0);
    readout(DEPTH + 2);

    $display("[TB] mode 2 trigger at first armed sample");
    capture(2'd2, 32'h200, 32'h200, 0);
    readout(12);

    $display("[TB] randomised captures");
    for (int n = 0; n < 6; n++) begin
      m    = 2'($urandom_range(0, 3));
      base = {$urandom_range(0, 16'hFFFE), 16'h0000};
      capture(m, base + 32'(4 * $urandom_range(0, 30)), base, 0);
      readout(DEPTH + 2);
    end

    $display("[TB] arm during readout");
    capture(2'd0, 32'h0, 32'h1000, 0);
    readout(3);
    bus.rd_req  = 1'b1;
    bus.arm     = 1'b1;
    bus.mode    = 2'd0;
    bus.trig_pc = '0;
    tick();
    bus.arm    = 1'b0;
    bus.rd_req = 1'b0;
    check("arm_rd_suppressed", bus.rd_valid, 0);
    check("rearm_state", bus.state, 2'd2);
    check("rearm_count", bus.count, 0);
    feed(2'd0, 32'h0, 32'h2000, 0);
    readout(20);

    $display("[TB] reset mid-capture");
    arm_capture(2'd0, 32'h0, 32'h3000);
    for (int i = 0; i < 5; i++) begin
      make_sample(32'h3000 + 32'(4 * i), 1'b1, s);
      drive_sample(s);
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    check("midrst_state", bus.state, 0);
    check("midrst_count", bus.count, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_overflow", bus.overflow, 0);
    check("midrst_rd_valid", bus.rd_valid, 0);
    check("midrst_rd_pc", bus.rd_pc, 0);
    check("midrst_rd_instr", bus.rd_instr, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("[TB] capture after reset");
    capture(2'd2, 32'h4000 + 32'(4 * 20), 32'h4000, 0);
    readout(DEPTH + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
